// File: rtl/pdm_capture_seq.sv
// PDM microphone capture sequencer: divides the system clock into the PDM bit clock,
// discards a settle period, samples mono/stereo bits and frames decimation windows.
module pdm_capture_seq #(
  parameter int DIV_W = 8,
  parameter int DEC_W = 12,
  parameter int SET_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable_i,
  input  logic [DIV_W-1:0] cfg_half_div_i,
  input  logic [DEC_W-1:0] cfg_decim_i,
  input  logic [SET_W-1:0] cfg_settle_i,
  input  logic             cfg_stereo_i,
  input  logic             cfg_irq_en_i,
  input  logic             pdm_data_i,
  input  logic             sample_ack_i,
  input  logic             ovr_clr_i,
  output logic             pdm_clk_out_o,
  output logic             bit_valid_o,
  output logic             bit_value_o,
  output logic             bit_chan_o,
  output logic             win_start_o,
  output logic             win_end_o,
  output logic             sample_pending_o,
  output logic             overrun_o,
  output logic             busy_o,
  output logic             irq_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_e;

  state_e state_q, state_d;

  logic [DIV_W-1:0] half_q, phase_q, phase_d;
  logic [DEC_W-1:0] decim_q, win_cnt_q, win_cnt_d;
  logic [SET_W-1:0] settle_q, fall_cnt_q, fall_cnt_d;
  logic             stereo_q;
  logic             clk_q, clk_d;
  logic             rose_q, rose_d;
  logic             last_q, last_d;
  logic             bv_q, bv_d, bval_q, bval_d, bchan_q, bchan_d;
  logic             ws_q, ws_d, we_q, we_d;
  logic             pend_q, pend_d, ovr_q, ovr_d;

  logic active, terminal, fall, settle_done;

  assign active      = (state_q != IDLE);
  assign terminal    = active && (phase_q == half_q - DIV_W'(1));
  assign fall        = terminal && clk_q;
  assign settle_done = (state_q == SETTLE) && fall && (fall_cnt_q == settle_q - SET_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_enable_i) state_d = (cfg_settle_i == '0) ? RUN : SETTLE;
      SETTLE:  if (!cfg_enable_i) state_d = IDLE;
               else if (settle_done) state_d = RUN;
      RUN:     if (!cfg_enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider, framing counters and bit strobes; disabling drops the cycle's sample.
  always_comb begin
    phase_d    = '0;
    clk_d      = 1'b0;
    rose_d     = 1'b0;
    fall_cnt_d = '0;
    win_cnt_d  = '0;
    last_d     = 1'b0;
    bv_d       = 1'b0;
    bval_d     = 1'b0;
    bchan_d    = 1'b0;
    ws_d       = 1'b0;
    we_d       = 1'b0;
    if (active && cfg_enable_i) begin
      phase_d    = terminal ? '0 : phase_q + DIV_W'(1);
      clk_d      = terminal ? ~clk_q : clk_q;
      rose_d     = rose_q | (terminal & ~clk_q);
      fall_cnt_d = fall_cnt_q;
      win_cnt_d  = win_cnt_q;
      last_d     = last_q;
      if ((state_q == SETTLE) && fall) fall_cnt_d = fall_cnt_q + SET_W'(1);
      if (state_q == RUN) begin
        if (fall) begin
          bv_d   = 1'b1;
          bval_d = pdm_data_i;
          ws_d   = (win_cnt_q == '0);
          if (win_cnt_q == decim_q - DEC_W'(1)) begin
            win_cnt_d = '0;
            if (stereo_q) last_d = 1'b1;
            else          we_d   = 1'b1;
          end else begin
            win_cnt_d = win_cnt_q + DEC_W'(1);
          end
        end else if (terminal && stereo_q && rose_q) begin
          bv_d    = 1'b1;
          bval_d  = pdm_data_i;
          bchan_d = 1'b1;
          we_d    = last_q;
          last_d  = 1'b0;
        end
      end
    end
    // A window ending alongside an ack keeps the new sample pending.
    pend_d = we_q ? 1'b1 : (sample_ack_i ? 1'b0 : pend_q);
    ovr_d  = (we_q && pend_q && !sample_ack_i) ? 1'b1 : (ovr_clr_i ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_q     <= '0;
      decim_q    <= '0;
      settle_q   <= '0;
      stereo_q   <= 1'b0;
    end else if ((state_q == IDLE) && cfg_enable_i) begin
      half_q     <= (cfg_half_div_i < DIV_W'(2)) ? DIV_W'(2) : cfg_half_div_i;
      decim_q    <= (cfg_decim_i == '0) ? DEC_W'(1) : cfg_decim_i;
      settle_q   <= cfg_settle_i;
      stereo_q   <= cfg_stereo_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= '0;
      clk_q      <= 1'b0;
      rose_q     <= 1'b0;
      fall_cnt_q <= '0;
      win_cnt_q  <= '0;
      last_q     <= 1'b0;
      bv_q       <= 1'b0;
      bval_q     <= 1'b0;
      bchan_q    <= 1'b0;
      ws_q       <= 1'b0;
      we_q       <= 1'b0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      clk_q      <= clk_d;
      rose_q     <= rose_d;
      fall_cnt_q <= fall_cnt_d;
      win_cnt_q  <= win_cnt_d;
      last_q     <= last_d;
      bv_q       <= bv_d;
      bval_q     <= bval_d;
      bchan_q    <= bchan_d;
      ws_q       <= ws_d;
      we_q       <= we_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    pdm_clk_out_o    = clk_q;
    bit_valid_o      = bv_q;
    bit_value_o      = bval_q;
    bit_chan_o       = bchan_q;
    win_start_o      = ws_q;
    win_end_o        = we_q;
    sample_pending_o = pend_q;
    overrun_o        = ovr_q;
    busy_o           = active;
    irq_o            = pend_q & cfg_irq_en_i;
  end

endmodule

// File: tb/tb_pdm_capture_seq.sv
// Self-checking bench for pdm_capture_seq: directed scenarios with random PDM data,
// checked every cycle against a time-based model of the clock, framing and flags.
module tb_pdm_capture_seq;
  localparam int DIV_W = 8;
  localparam int DEC_W = 12;
  localparam int SET_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_enable = 1'b0;
  logic [DIV_W-1:0] cfg_half_div = '0;
  logic [DEC_W-1:0] cfg_decim = '0;
  logic [SET_W-1:0] cfg_settle = '0;
  logic cfg_stereo = 1'b0;
  logic cfg_irq_en = 1'b0;
  logic pdm_data = 1'b0;
  logic sample_ack = 1'b0;
  logic ovr_clr = 1'b0;
  logic pdm_clk_out, bit_valid, bit_value, bit_chan, win_start, win_end;
  logic sample_pending, overrun, busy, irq;

  always #5 clk = ~clk;

  pdm_capture_seq #(.DIV_W(DIV_W), .DEC_W(DEC_W), .SET_W(SET_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_enable_i(cfg_enable), .cfg_half_div_i(cfg_half_div), .cfg_decim_i(cfg_decim),
    .cfg_settle_i(cfg_settle), .cfg_stereo_i(cfg_stereo), .cfg_irq_en_i(cfg_irq_en),
    .pdm_data_i(pdm_data), .sample_ack_i(sample_ack), .ovr_clr_i(ovr_clr),
    .pdm_clk_out_o(pdm_clk_out), .bit_valid_o(bit_valid), .bit_value_o(bit_value),
    .bit_chan_o(bit_chan), .win_start_o(win_start), .win_end_o(win_end),
    .sample_pending_o(sample_pending), .overrun_o(overrun), .busy_o(busy), .irq_o(irq)
  );

  int checks = 0;
  int failures = 0;

  // Model: elapsed cycles since leaving IDLE plus the latched configuration.
  bit mActive = 1'b0;
  int mT = 0, mHd = 2, mDec = 1, mSet = 0;
  bit mStereo = 1'b0;
  bit eBv = 0, eVal = 0, eChan = 0, eWs = 0, eWe = 0, ePend = 0, eOvr = 0;

  bit followClock = 1'b0;
  bit ackOnEnd = 1'b0;
  bit randomPulses = 1'b0;

  function automatic bit expClk();
    return mActive && (((mT / mHd) % 2) == 1);
  endfunction

  task automatic checkOutput(input string tag);
    logic [7:0] obs, exp;
    logic [1:0] dObs, dExp;
    obs = {pdm_clk_out, bit_valid, win_start, win_end, sample_pending, overrun, busy, irq};
    exp = {expClk(), eBv, eWs, eWe, ePend, eOvr, mActive, ePend & cfg_irq_en};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s ctrl{clk,bv,ws,we,pend,ovr,busy,irq} t=%0d got=%b want=%b", tag, mT, obs, exp);
    end
    if (eBv) begin
      dObs = {bit_value, bit_chan};
      dExp = {eVal, eChan};
      checks++;
      assert (dObs === dExp) else begin
        failures++;
        $error("[TB] FAIL %s data{value,chan} t=%0d got=%b want=%b", tag, mT, dObs, dExp);
      end
    end
  endtask

  task automatic modelStep();
    bit nBv = 0, nVal = 0, nChan = 0, nWs = 0, nWe = 0, nPend, nOvr;
    int k, n, m, pos;
    if (!rst_n) begin
      mActive = 0; mT = 0;
      nPend = 0; nOvr = 0;
    end else begin
      nPend = eWe ? 1'b1 : (sample_ack ? 1'b0 : ePend);
      nOvr  = (eWe && ePend && !sample_ack) ? 1'b1 : (ovr_clr ? 1'b0 : eOvr);
      if (!mActive) begin
        if (cfg_enable) begin
          mHd = (int'(cfg_half_div) < 2) ? 2 : int'(cfg_half_div);
          mDec = (int'(cfg_decim) == 0) ? 1 : int'(cfg_decim);
          mSet = int'(cfg_settle);
          mStereo = cfg_stereo;
          mActive = 1; mT = 0;
        end
      end else if (!cfg_enable) begin
        mActive = 0;
      end else begin
        if (((mT + 1) % mHd) == 0) begin
          k = (mT + 1) / mHd;
          if ((k % 2) == 0) begin
            n = k / 2;
            if (n > mSet) begin
              pos = (n - mSet - 1) % mDec;
              nBv = 1; nVal = pdm_data; nChan = 0;
              nWs = (pos == 0);
              nWe = !mStereo && (pos == mDec - 1);
            end
          end else begin
            m = (k - 1) / 2;
            if (mStereo && m >= 1 && m >= mSet) begin
              nBv = 1; nVal = pdm_data; nChan = 1;
              nWe = (m > mSet) && (((m - mSet - 1) % mDec) == mDec - 1);
            end
          end
        end
        mT++;
      end
    end
    eBv = nBv; eVal = nVal; eChan = nChan; eWs = nWs; eWe = nWe; ePend = nPend; eOvr = nOvr;
  endtask

  task automatic applyStimulus(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      #1;
      checkOutput(tag);
      pdm_data = followClock ? expClk() : 1'($urandom_range(1, 0));
      if (randomPulses) begin
        sample_ack = ($urandom_range(4, 0) == 0);
        ovr_clr = ($urandom_range(6, 0) == 0);
      end else if (ackOnEnd) begin
        sample_ack = eWe;
      end
      modelStep();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    $display("[TB] start");
    @(posedge clk); #1;
    applyStimulus(3, "reset");
    rst_n = 1'b1;
    applyStimulus(3, "idle");

    cfg_half_div = 8'd5; cfg_decim = 12'd4; cfg_settle = 12'd0; cfg_stereo = 1'b0;
    cfg_enable = 1'b1;
    applyStimulus(70, "clkgen");
    cfg_half_div = 8'd9; cfg_decim = 12'd2;
    applyStimulus(20, "latched");
    cfg_enable = 1'b0;
    applyStimulus(2, "disable1");
    sample_ack = 1'b1; ovr_clr = 1'b1;
    applyStimulus(1, "ackclr");
    sample_ack = 1'b0; ovr_clr = 1'b0;

    cfg_half_div = 8'd2; cfg_decim = 12'd3; cfg_settle = 12'd3;
    cfg_enable = 1'b1;
    applyStimulus(40, "settle");
    cfg_enable = 1'b0;
    applyStimulus(2, "disable2");

    cfg_half_div = 8'd3; cfg_decim = 12'd4; cfg_settle = 12'd1; cfg_stereo = 1'b1;
    cfg_irq_en = 1'b1; followClock = 1'b1;
    cfg_enable = 1'b1;
    applyStimulus(80, "stereo");
    cfg_irq_en = 1'b0;
    applyStimulus(3, "irqlive");
    followClock = 1'b0; cfg_enable = 1'b0;
    applyStimulus(2, "disable3");

    cfg_half_div = 8'd2; cfg_decim = 12'd2; cfg_settle = 12'd0; cfg_stereo = 1'b0;
    cfg_enable = 1'b1;
    applyStimulus(40, "overrun");
    ovr_clr = 1'b1;
    applyStimulus(1, "ovrclr");
    ovr_clr = 1'b0; ackOnEnd = 1'b1;
    applyStimulus(40, "ackonend");
    ackOnEnd = 1'b0; cfg_enable = 1'b0;
    applyStimulus(2, "disable4");

    cfg_half_div = 8'd0; cfg_decim = 12'd0;
    cfg_enable = 1'b1;
    applyStimulus(30, "clamp");
    cfg_enable = 1'b0;
    applyStimulus(2, "disable5");

    cfg_half_div = 8'd2; cfg_decim = 12'd4;
    cfg_enable = 1'b1;
    applyStimulus(10, "midwin");
    cfg_enable = 1'b0;
    applyStimulus(3, "midwinoff");
    cfg_enable = 1'b1;
    applyStimulus(30, "reenable");

    rst_n = 1'b0;
    applyStimulus(2, "midreset");
    rst_n = 1'b1; cfg_enable = 1'b0;
    applyStimulus(2, "postreset");

    randomPulses = 1'b1;
    for (int r = 0; r < 8; r++) begin
      cfg_half_div = 8'($urandom_range(6, 0));
      cfg_decim = 12'($urandom_range(5, 0));
      cfg_settle = 12'($urandom_range(3, 0));
      cfg_stereo = 1'($urandom_range(1, 0));
      cfg_irq_en = 1'($urandom_range(1, 0));
      cfg_enable = 1'b1;
      applyStimulus(int'($urandom_range(90, 30)), "random");
      cfg_half_div = 8'($urandom_range(6, 0));
      cfg_stereo = ~cfg_stereo;
      applyStimulus(20, "randlatch");
      cfg_enable = 1'b0;
      applyStimulus(int'($urandom_range(3, 1)), "randoff");
    end
    randomPulses = 1'b0; sample_ack = 1'b0; ovr_clr = 1'b0;
    applyStimulus(2, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pdm_capture_seq.md
Name: pdm_capture_seq

Overview:
- Sequencer for the PDM microphone peripheral.
- Generates the PDM bit clock from the 64 MHz system clock with a programmable divider, and runs a settle period after enable.
- Samples mono or stereo PDM data on the correct clock phase and frames decimation windows for the downstream PCM filter.
- Raises a sample-ready interrupt with acknowledge and overrun tracking.
- Sits between the CPU-visible control registers and the decimation datapath.

Parameters:
- DIV_W, 8, width of the half-period divider setting.
- DEC_W, 12, width of the decimation-length setting (PDM bits per PCM sample).
- SET_W, 12, width of the settle-count setting (PDM clock periods discarded after enable).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cfg_enable  in  1  run request; low returns to IDLE
- cfg_half_div  in  DIV_W  pdm_clk half period in clk cycles; values 0 and 1 are treated as 2
- cfg_decim  in  DEC_W  bits per window per channel; 0 is treated as 1
- cfg_settle  in  SET_W  settle periods; 0 skips SETTLE
- cfg_stereo  in  1  1 = also capture the channel-1 bit on the low phase
- cfg_irq_en  in  1  interrupt enable
- pdm_data  in  1  microphone data, already synchronized
- sample_ack  in  1  one-cycle pulse: CPU consumed the PCM sample
- ovr_clr  in  1  one-cycle pulse: clear the overrun flag
- pdm_clk_out  out  1  microphone clock
- bit_valid  out  1  one-cycle strobe: bit_value/bit_chan are valid
- bit_value  out  1  sampled PDM bit
- bit_chan  out  1  0 = channel 0 (high phase), 1 = channel 1 (low phase)
- win_start  out  1  coincident with the first channel-0 bit of a window; filter clears its accumulators
- win_end  out  1  coincident with the last bit of a window (ch0 in mono, ch1 in stereo)
- sample_pending  out  1  a window completed and has not been acknowledged
- overrun  out  1  sticky flag: a window ended while pending was still set
- busy  out  1  state != IDLE
- irq  out  1  sample_pending & cfg_irq_en

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Configuration latching:
  - cfg_half_div, cfg_decim, cfg_settle and cfg_stereo are latched on the IDLE->active transition.
  - Changes to these inputs while busy are ignored.
  - cfg_irq_en is live.
- States: IDLE, SETTLE, RUN.
- IDLE:
  - pdm_clk_out=0, phase counter 0, no strobes.
  - When cfg_enable=1: go to SETTLE, or straight to RUN if latched settle = 0.
- Clock generation (SETTLE and RUN):
  - Phase counter increments each cycle.
  - At terminal count (latched half_div - 1), pdm_clk_out toggles and the counter wraps to 0.
  - The first toggle is low->high, half_div cycles after leaving IDLE.
  - Period = 2*half_div clk cycles; duty 50%.
- Sampling, at the terminal-count cycle, using the pdm_data value in that cycle:
  - If pdm_clk_out=1 (falling edge next), take channel 0.
  - If pdm_clk_out=0 and stereo, take channel 1.
  - No channel-1 sample is taken before the first rising edge.
  - bit_valid, bit_value and bit_chan are registered and appear 1 cycle later.
- SETTLE:
  - Counts falling edges.
  - After `settle` falling edges, go to RUN.
  - bit_valid stays 0 throughout SETTLE.
- RUN:
  - Every sampled bit is emitted.
  - The window counter counts channel-0 bits from 0 to decim-1.
  - win_start accompanies the bit where the count is 0.
  - Mono: win_end accompanies the channel-0 bit where the count is decim-1.
  - Stereo: win_end accompanies the following channel-1 bit instead.
  - The counter wraps to 0 after the last bit; windows are back-to-back with no gap bits.
  - decim=1 with mono: win_start and win_end assert on the same bit.
- Pending and overrun:
  - win_end sets sample_pending.
  - sample_ack clears it.
  - win_end and sample_ack in the same cycle: pending stays 1, overrun unchanged.
  - win_end while pending=1 with no ack: overrun set.
  - ovr_clr clears overrun; a simultaneous set wins.
  - sample_ack while pending=0 is ignored.
- Disable:
  - cfg_enable=0 in SETTLE or RUN: next cycle state IDLE, pdm_clk_out=0, window counter cleared, partial window discarded (no win_end).
  - Bits sampled in the disable cycle are discarded.
  - sample_pending and overrun are preserved.
- Reset mid-operation: everything returns to reset values on the next edge, including pending and overrun.

Test Plan:
- Clock generation: half_div=5, settle=0, mono, enable -> pdm_clk_out period 10 cycles, first rise 5 cycles after enable; bit_valid every 10 cycles, 1 cycle after each falling-edge terminal, bit_chan=0.
- Settle period: settle=3, half_div=2 -> no bit_valid for the first 3 falling edges; the first bit_valid follows the 4th falling edge, with win_start=1.
- Stereo framing: stereo, decim=4, pdm_data=1 during high phases and 0 during low phases -> per window, bits 1,0 ×4 with bit_chan alternating 0,1; win_end on the 8th bit (chan 1); sample_pending then irq rise with cfg_irq_en=1.
- Ack and overrun: decim=2 mono, never ack -> overrun sets at the second win_end; ack issued in the same cycle as a later win_end -> pending stays 1 and overrun does not re-set after ovr_clr.
- Divider clamp and decim=1: half_div=0, decim=0 -> period 4 cycles; every bit carries win_start and win_end.
- Disable and reset: disable mid-window after 2 of 4 bits -> no win_end, busy=0, clock low next cycle, pending preserved; re-enable -> win_start on the first bit. rst_n low during RUN -> all outputs 0 next cycle.
